// File: rtl/aram_uart_dump.sv
// Streams a contiguous ARAM region out of uart_txd as 8N1 frames.
// Optional DUMP_CHECKSUM_EN appends a frame holding the 8-bit modular sum of the sent bytes.
`timescale 1ns/1ps
module aram_uart_dump #(
  parameter int CLK_FREQ = 24_469_000,
  parameter int BAUD     = 115_200
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [16:0] base,
  input  logic [16:0] count,
  output logic        busy,
  output logic        done,
  output logic        aram_rd,
  output logic [16:0] aram_a,
  input  logic [7:0]  aram_dout,
  output logic        uart_txd
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5,
`ifdef DUMP_CHECKSUM_EN
    SUM   = 3'd7,
`endif
    FIN   = 3'd6
  } state_t;

  state_t          state, state_nxt;
  logic [16:0]     addr;
  logic [16:0]     remaining;
  logic [7:0]      shift;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic            baud_tc;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]      checksum;
  logic            sum_sent;
`endif

  assign baud_tc = (baud_cnt == '0);
  assign aram_a  = addr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      // count==0 takes a one-cycle STOP so done lands two cycles after start
      IDLE:  if (start) state_nxt = (count != '0) ? FETCH : STOP;
      FETCH: state_nxt = LATCH;
      LATCH: state_nxt = START;
      START: if (baud_tc) state_nxt = DATA;
      DATA:  if (baud_tc && bit_cnt == 3'd7) state_nxt = STOP;
      STOP: begin
        if (baud_tc) begin
          if (remaining != '0) state_nxt = FETCH;
`ifdef DUMP_CHECKSUM_EN
          else if (!sum_sent)  state_nxt = SUM;
`endif
          else                 state_nxt = FIN;
        end
      end
`ifdef DUMP_CHECKSUM_EN
      SUM:   state_nxt = START;
`endif
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b1;
    done     = 1'b0;
    aram_rd  = 1'b0;
    uart_txd = 1'b1;
    case (state)
      IDLE:  busy = 1'b0;
      FETCH: aram_rd = 1'b1;
      START: uart_txd = 1'b0;
      DATA:  uart_txd = shift[0];
      FIN: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr      <= '0;
      remaining <= '0;
      shift     <= '0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
`ifdef DUMP_CHECKSUM_EN
      checksum  <= '0;
      sum_sent  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= base;
            remaining <= count;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
`ifdef DUMP_CHECKSUM_EN
            checksum  <= '0;
            sum_sent  <= 1'b0;
`endif
          end
        end
        LATCH: begin
          shift     <= aram_dout;
          addr      <= addr + 17'd1;
          remaining <= remaining - 17'd1;
          baud_cnt  <= BAUD_LAST;
          bit_cnt   <= '0;
`ifdef DUMP_CHECKSUM_EN
          checksum  <= checksum + aram_dout;
`endif
        end
        START: baud_cnt <= baud_tc ? BAUD_LAST : baud_cnt - 1'b1;
        DATA: begin
          if (baud_tc) begin
            baud_cnt <= BAUD_LAST;
            shift    <= {1'b0, shift[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        STOP: if (!baud_tc) baud_cnt <= baud_cnt - 1'b1;
`ifdef DUMP_CHECKSUM_EN
        SUM: begin
          shift    <= checksum;
          sum_sent <= 1'b1;
          baud_cnt <= BAUD_LAST;
          bit_cnt  <= '0;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
